// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

   localparam int unsigned DefN             = 8;
   localparam int unsigned DefNreq          = 4;
   localparam int unsigned DefTimeoutCycles = 60000;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWait,
      StDone
   } arb_state_e;

   // Bits needed to count 0 .. limit-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

   localparam int unsigned DefCntW = cnt_width(DefTimeoutCycles);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first pending requester after last_ptr, wrapping around.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IdW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IdW-1:0]  last_ptr,
   output logic            valid,
   output logic [IdW-1:0]  idx
);

   logic           hi_valid;
   logic           lo_valid;
   logic [IdW-1:0] hi_idx;
   logic [IdW-1:0] lo_idx;

   // Lowest requester above last_ptr wins; if none, wrap to the lowest requester overall.
   always_comb begin
      hi_valid = 1'b0;
      lo_valid = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req[i] && !lo_valid) begin
            lo_valid = 1'b1;
            lo_idx   = IdW'(i);
         end
         if (req[i] && (i > 32'(last_ptr)) && !hi_valid) begin
            hi_valid = 1'b1;
            hi_idx   = IdW'(i);
         end
      end
   end

   assign valid = lo_valid;
   assign idx   = hi_valid ? hi_idx : lo_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uart_tx from NREQ byte requesters, with a completion watchdog.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned N              = DefN,
   parameter int unsigned NREQ           = DefNreq,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
   localparam int unsigned IdW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] req_data,
   output logic [NREQ-1:0]   ack,
   output logic              tx_start,
   output logic [N-1:0]      tx_data,
   input  logic              tx_done,
   output logic              busy,
   output logic [IdW-1:0]    grant_id,
   output logic              timeout_err
);

   localparam int unsigned    CntW    = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [IdW-1:0]  PtrRst  = IdW'(NREQ - 1);

   arb_state_e     state_q, state_d;
   logic [N-1:0]   tx_data_q, tx_data_d;
   logic [IdW-1:0] grant_q, grant_d;
   logic [IdW-1:0] last_ptr_q, last_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic           timeout_q, timeout_d;
   logic           pick_valid;
   logic [IdW-1:0] pick_idx;

   rr_pick #(
      .NREQ (NREQ),
      .IdW  (IdW)
   ) u_rr_pick (
      .req      (req),
      .last_ptr (last_ptr_q),
      .valid    (pick_valid),
      .idx      (pick_idx)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus datapath/watchdog next values.
   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      grant_d    = grant_q;
      last_ptr_d = last_ptr_q;
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               for (int unsigned i = 0; i < NREQ; i++) begin
                  if (IdW'(i) == pick_idx) tx_data_d = req_data[i*N +: N];
               end
               grant_d = pick_idx;
               state_d = StStart;
            end
         end
         StStart: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // cnt_q == 0 marks the first WAIT cycle, where tx_done is ignored.
            if ((cnt_q != '0) && tx_done) begin
               last_ptr_d = grant_q;
               state_d    = StDone;
            end else if (cnt_q == CntLast) begin
               timeout_d  = 1'b1;
               last_ptr_d = grant_q;
               state_d    = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            // Wait for a level-style tx_done to drop before rearming.
            if (!tx_done) begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath, pointer and watchdog registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_data_q  <= '0;
         grant_q    <= '0;
         last_ptr_q <= PtrRst;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         tx_data_q  <= tx_data_d;
         grant_q    <= grant_d;
         last_ptr_q <= last_ptr_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      busy     = (state_q != StIdle);
      tx_start = (state_q == StStart);
      ack      = '0;
      if (state_q == StStart) ack = NREQ'(1) << grant_q;
   end

   assign tx_data     = tx_data_q;
   assign grant_id    = grant_q;
   assign timeout_err = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- N, default 8, data width in bits.
- NREQ, default 4, number of requesters.
- TIMEOUT_CYCLES, default 60000, watchdog limit in clk cycles.
REQ-002 The block SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  requester i has a byte pending.
- req_data  in  NREQ*N  byte of requester i at [i*N +: N].
- ack  out  NREQ  one-cycle pulse: byte of requester i accepted.
- tx_start  out  1  to uart_tx start_tx.
- tx_data  out  N  to uart_tx data_in.
- tx_done  in  1  from uart_tx tx_done.
- busy  out  1  high in any state except IDLE.
- grant_id  out  clog2(NREQ)  index of the current or last granted requester.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-003 The FSM SHALL have four states:
- IDLE: no transfer in progress.
- START: byte issued to uart_tx.
- WAIT: waiting for tx_done or timeout.
- DONE: waiting for tx_done to return low.
REQ-004 IDLE SHALL behave as follows when any req bit is high at a rising edge:
- Select the winner by round-robin, searching from (last_ptr+1) mod NREQ upward with wrap-around.
- Register the winner's req_data into tx_data and its index into grant_id.
- Enter START.
REQ-005 In START, for exactly one cycle:
- tx_start SHALL be 1.
- ack[grant_id] SHALL be 1.
- Then the FSM SHALL enter WAIT.
- Latency from req sampled to tx_start/ack is therefore one cycle.
REQ-006 tx_data SHALL hold constant from START until the FSM next leaves IDLE.
REQ-007 A requester that drops req before its ack is withdrawn. A req still high in the cycle of its own ack SHALL NOT be re-granted within that same arbitration.
REQ-008 In WAIT, the FSM SHALL ignore tx_done in the first WAIT cycle; tx_done=1 from the second WAIT cycle onward SHALL move the FSM to DONE.
REQ-009 In WAIT, a cycle counter SHALL count from 0. When it reaches TIMEOUT_CYCLES-1 without tx_done:
- timeout_err SHALL pulse for one cycle.
- The FSM SHALL move to DONE.
- If tx_done and timeout occur in the same cycle, tx_done wins and timeout_err stays 0.
REQ-010 On entering DONE, last_ptr SHALL be set to grant_id. The FSM SHALL return to IDLE on the first cycle tx_done=0, so a level-style tx_done cannot re-trigger completion.
REQ-011 New req edges arriving in START, WAIT or DONE SHALL NOT be lost while req is held; they are arbitrated at the next IDLE.
REQ-012 Only one ack bit SHALL ever be high in a cycle, and ack SHALL never be high outside START.
REQ-013 With NREQ=1 the arbiter SHALL degenerate to a pass-through sequencer; grant_id is then 0.

Reset
REQ-014 When reset=0, immediately and independent of clk:
- FSM=IDLE.
- tx_start=0, ack=0, busy=0, timeout_err=0.
- tx_data=0, grant_id=0.
- last_ptr=NREQ-1, so requester 0 has first priority.
- Watchdog counter=0.
REQ-015 Reset asserted mid-transfer SHALL abort the transfer with no ack or timeout_err pulse emitted. Release SHALL take effect synchronously at the next rising edge.

Structure
REQ-016 A shared package SHALL hold:
- the state enumeration (IDLE, START, WAIT, DONE);
- the default N, NREQ and TIMEOUT_CYCLES;
- the counter-width helper constant.
REQ-017 The round-robin search SHALL be a sub-module rr_pick, purely combinational: inputs req, last_ptr; outputs valid, idx. The FSM, registers and watchdog SHALL stay in uart_tx_arbiter.

Verification
REQ-018 The bench SHALL use uart_tx plus baudrate_generator (9600 baud, 50 MHz clock) and cover these directed scenarios:
- Single request: req=4'b0001, req_data[7:0]=8'hAA -> ack[0] and tx_start together, one cycle after req; tx_data=8'hAA; line frame shows 0xAA; busy low after tx_done falls.
- All four request (data 8'h11, 8'h22, 8'h33, 8'h44), held until ack -> grants 0,1,2,3 in order; exactly one ack per frame; four frames back-to-back.
- Fairness after reset: grant 2 completes, then req=4'b0101 -> next grant is 0, then 2 (wrap-around).
- Watchdog: tx_done tied 0 with TIMEOUT_CYCLES=100 -> timeout_err pulses 101 cycles after tx_start; FSM in DONE; IDLE next cycle.
- Level-style tx_done: hold tx_done=1 for 5 cycles with req=4'b0010 pending -> only one completion; req1 granted only after tx_done=0.
- Reset mid-frame: reset=0 during WAIT -> all outputs at reset values the same cycle; no ack or timeout_err; normal grant works after release.
